regfile_dump: RTL and testbench

Debug reader for the 32-entry integer register file. On a start pulse it drives the register file's read-select port through x0..x31 in order and snapshots each value. It presents every value on a valid/ready output stream for a debug UART, trace buffer or testbench checker. It sits beside the core and uses one spare read port, so the core's own write port stays untouched.

---
 rtl/regfile_dump_pkg.sv | 16 +
 rtl/regfile.sv | 33 +++
 rtl/regfile_dump.sv | 104 ++++++++++
 tb/tb_regfile_dump.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_dump_pkg.sv
// Shared sizing defaults and dump FSM encoding for the register-file debug reader
// and the register file it reads.
package regfile_dump_pkg;

  localparam int DEF_NUM_REGS = 32;
  localparam int DEF_ADDR_W   = 5;
  localparam int DEF_DATA_W   = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } dump_state_e;

endpackage

// File: rtl/regfile.sv
// Integer register file: one write port, two combinational read ports, x0 hardwired to zero.
// Port 2 is the spare read port used by the debug dump reader.
module regfile #(
  parameter int NUM_REGS = regfile_dump_pkg::DEF_NUM_REGS,
  parameter int ADDR_W   = regfile_dump_pkg::DEF_ADDR_W,
  parameter int DATA_W   = regfile_dump_pkg::DEF_DATA_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] reg_1_select,
  output logic [DATA_W-1:0] reg_1,
  input  logic [ADDR_W-1:0] reg_2_select,
  output logic [DATA_W-1:0] reg_2
);

  logic [DATA_W-1:0] r_regs [NUM_REGS];

  // x0 is never written, so it keeps its reset value of zero.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (we && (waddr != '0)) begin
      r_regs[waddr] <= wdata;
    end
  end

  assign reg_1 = r_regs[reg_1_select];
  assign reg_2 = r_regs[reg_2_select];

endmodule

// File: rtl/regfile_dump.sv
// Walks the register file x0..x(NUM_REGS-1) through a spare read port and streams
// each snapshot out over a valid/ready interface, pulsing done at the end.
module regfile_dump #(
  parameter int NUM_REGS = regfile_dump_pkg::DEF_NUM_REGS,
  parameter int ADDR_W   = regfile_dump_pkg::DEF_ADDR_W,
  parameter int DATA_W   = regfile_dump_pkg::DEF_DATA_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] rd_select,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_index,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic [1:0]        state_dbg
);

  import regfile_dump_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  // Stream handshake: out_index/out_data are held stable while out_valid is high;
  // a transfer happens on any edge where out_valid && out_ready, and out_valid only
  // falls after a transfer, on abort, or on reset.
  dump_state_e       r_state;
  logic [ADDR_W-1:0] r_idx;
  logic              r_out_valid;
  logic [ADDR_W-1:0] r_out_index;
  logic [DATA_W-1:0] r_out_data;
  logic              r_done;
  logic              w_xfer;

  assign w_xfer = r_out_valid && out_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_out_valid <= 1'b0;
      r_out_index <= '0;
      r_out_data  <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start && !abort) begin
            r_idx   <= '0;
            r_state <= READ;
          end
        end
        READ: begin
          if (abort) begin
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_out_data  <= rd_data;
            r_out_index <= r_idx;
            r_out_valid <= 1'b1;
            r_state     <= HOLD;
          end
        end
        HOLD: begin
          // A transfer coinciding with abort is still delivered; abort only ends the walk.
          if (abort) begin
            r_out_valid <= 1'b0;
            r_done      <= 1'b1;
            r_state     <= DONE;
          end else if (w_xfer) begin
            r_out_valid <= 1'b0;
            if (r_idx == LAST_IDX) begin
              r_done  <= 1'b1;
              r_state <= DONE;
            end else begin
              r_idx   <= r_idx + ADDR_W'(1);
              r_state <= READ;
            end
          end
        end
        DONE: begin
          r_idx   <= '0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rd_select = r_idx;
  assign out_valid = r_out_valid;
  assign out_index = r_out_index;
  assign out_data  = r_out_data;
  assign out_last  = r_out_valid && (r_out_index == LAST_IDX);
  assign busy      = (r_state != IDLE);
  assign done      = r_done;
  assign state_dbg = r_state;

endmodule

// File: tb/tb_regfile_dump.sv
// Bench for regfile_dump wired to the register file's spare read port.
module tb_regfile_dump;
  import regfile_dump_pkg::*;

  localparam int NR = 32;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int W  = AW + DW;

  // ---------------- clock / reset ----------------
  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  logic          start = 1'b0, abort = 1'b0, out_ready = 1'b0, we = 1'b0;
  logic [AW-1:0] waddr = '0, reg_1_select = '0;
  logic [DW-1:0] wdata = '0;
  logic [AW-1:0] rd_select, out_index;
  logic [DW-1:0] rd_data, out_data, reg_1;
  logic          out_valid, out_last, busy, done;
  logic [1:0]    state_dbg;

  regfile #(.NUM_REGS(NR), .ADDR_W(AW), .DATA_W(DW)) u_rf (
    .clock(clock), .reset_n(reset_n), .we(we), .waddr(waddr), .wdata(wdata),
    .reg_1_select(reg_1_select), .reg_1(reg_1),
    .reg_2_select(rd_select), .reg_2(rd_data)
  );

  regfile_dump #(.NUM_REGS(NR), .ADDR_W(AW), .DATA_W(DW)) u_dut (
    .clock(clock), .reset_n(reset_n), .start(start), .abort(abort),
    .rd_select(rd_select), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index),
    .out_data(out_data), .out_last(out_last), .busy(busy), .done(done),
    .state_dbg(state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int            n_checks = 0;
  int            n_pass   = 0;
  logic [W-1:0]  exp_q[$];
  logic [DW-1:0] rf_model[NR];
  int            edge_cnt = 0;
  int            ready_mode = 0;   // 0 manual, 1 random with stall on index 5, 2 hold at hold_idx
  int            hold_idx = 0;
  logic          released = 1'b0;
  int            stall_cnt = 0;
  logic          stall_chk = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
  endtask

  always @(posedge clock) edge_cnt++;

  // ready driver, updated just after each active edge
  always @(posedge clock) begin
    #1;
    stall_chk = 1'b0;
    case (ready_mode)
      1: begin
        if (out_valid && out_index == AW'(5) && stall_cnt < 7) begin
          out_ready = 1'b0;
          stall_cnt++;
          stall_chk = 1'b1;
        end else begin
          out_ready = 1'($urandom_range(0, 1));
        end
      end
      2: out_ready = !(out_valid && out_index == AW'(hold_idx) && !released);
      default: ;
    endcase
  end

  // transfer monitor on the falling edge
  always @(negedge clock) begin
    logic [W-1:0] e;
    if (stall_chk) begin
      check("stall_data", out_data, 32'h1000_0005);
      check("stall_index", out_index, 5);
    end
    if (out_valid && out_ready) begin
      check("q_nonempty", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("xfer_index", out_index, e[W-1:DW]);
        check("xfer_data", out_data, e[DW-1:0]);
        check("xfer_last", out_last, e[W-1:DW] == AW'(NR - 1));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic rf_write(input int a, input logic [DW-1:0] d);
    we = 1'b1; waddr = AW'(a); wdata = d;
    tick();
    we = 1'b0;
    if (a != 0) rf_model[a] = d;
  endtask

  task automatic push_exp(input int first, input int last);
    for (int i = first; i <= last; i++) exp_q.push_back({AW'(i), rf_model[i]});
  endtask

  task automatic pulse_start(output int e0);
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    e0 = edge_cnt;
  endtask

  task automatic wait_done(input int e0, input int budget, output int edges);
    edges = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (done) begin
        edges = edge_cnt - e0;
        break;
      end
    end
    tick();
  endtask

  task automatic wait_hold(input int k, input int budget, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (out_valid && out_index == AW'(k)) begin
        ok = 1'b1;
        break;
      end
    end
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int   e0, edges;
    logic ok;

    repeat (3) @(posedge clock);
    #1;
    check("rst_rd_select", rd_select, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_index", out_index, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_state", state_dbg, IDLE);
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < NR; i++) rf_model[i] = '0;
    for (int i = 1; i < NR; i++) rf_write(i, 32'h1000_0000 + DW'(i));

    // full dump, consumer always ready
    out_ready = 1'b1;
    push_exp(0, NR - 1);
    pulse_start(e0);
    check("e0_busy", busy, 1);
    check("e0_state", state_dbg, READ);
    check("e0_rd_select", rd_select, 0);
    @(negedge clock);
    check("e0_valid_low", out_valid, 0);
    @(negedge clock);
    check("e1_valid", out_valid, 1);
    check("e1_index", out_index, 0);
    wait_done(e0, 200, edges);
    check("full_done_edge", edges, 64);
    check("full_busy_clear", busy, 0);
    check("full_q_empty", exp_q.size(), 0);

    // random backpressure with a 7-cycle stall on index 5
    stall_cnt = 0;
    ready_mode = 1;
    push_exp(0, NR - 1);
    pulse_start(e0);
    wait_done(e0, 2000, edges);
    check("rand_done_seen", edges > 0, 1);
    check("rand_stall_len", stall_cnt, 7);
    check("rand_q_empty", exp_q.size(), 0);
    ready_mode = 0;
    out_ready = 1'b0;

    // snapshot: x20 written before its READ, x3 written after its sample
    hold_idx = 10; released = 1'b0; ready_mode = 2;
    rf_model[20] = 32'hDEAD_BEEF;
    push_exp(0, NR - 1);
    pulse_start(e0);
    wait_hold(10, 200, ok);
    check("snap_hold10_seen", ok, 1);
    rf_write(20, 32'hDEAD_BEEF);
    rf_write(3, 32'h3333_3333);
    check("snap_hold_index", out_index, 10);
    check("snap_hold_data", out_data, 32'h1000_000A);
    released = 1'b1;
    wait_done(e0, 400, edges);
    check("snap_done_seen", edges > 0, 1);
    check("snap_q_empty", exp_q.size(), 0);

    // abort while holding index 12 with the consumer stalled
    hold_idx = 12; released = 1'b0;
    push_exp(0, 11);
    pulse_start(e0);
    wait_hold(12, 200, ok);
    check("abort_hold12_seen", ok, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    @(negedge clock);
    check("abort_done", done, 1);
    check("abort_valid_low", out_valid, 0);
    check("abort_state", state_dbg, DONE);
    tick();
    check("abort_done_clear", done, 0);
    check("abort_busy_clear", busy, 0);
    check("abort_q_empty", exp_q.size(), 0);
    ready_mode = 0;
    out_ready = 1'b1;
    push_exp(0, NR - 1);
    pulse_start(e0);
    wait_done(e0, 200, edges);
    check("restart_done_edge", edges, 64);
    check("restart_q_empty", exp_q.size(), 0);

    // start held high mid-dump must not restart the walk
    push_exp(0, NR - 1);
    start = 1'b1;
    @(posedge clock);
    #1;
    e0 = edge_cnt;
    repeat (40) tick();
    start = 1'b0;
    wait_done(e0, 200, edges);
    check("held_start_done_edge", edges, 64);
    check("held_start_q_empty", exp_q.size(), 0);

    // start with abort in IDLE is ignored
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    repeat (3) tick();
    check("start_abort_busy", busy, 0);
    check("start_abort_valid", out_valid, 0);

    // asynchronous reset while holding index 8
    hold_idx = 8; released = 1'b0; ready_mode = 2;
    push_exp(0, 7);
    pulse_start(e0);
    wait_hold(8, 200, ok);
    check("rst_hold8_seen", ok, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_out_index", out_index, 0);
    check("arst_out_data", out_data, 0);
    check("arst_rd_select", rd_select, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_q_empty", exp_q.size(), 0);
    repeat (2) begin
      @(negedge clock);
      check("arst_no_done", done, 0);
    end
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    ready_mode = 0;
    out_ready = 1'b1;
    for (int i = 0; i < NR; i++) rf_model[i] = '0;
    tick();
    rf_write(8, 32'hA5A5_0008);
    rf_write(31, 32'hA5A5_001F);
    push_exp(0, NR - 1);
    pulse_start(e0);
    wait_done(e0, 200, edges);
    check("post_rst_done_edge", edges, 64);
    check("post_rst_q_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
